// File: rtl/ahb_multi_timer.sv
// Bank of independent down-counters used as timeout/interval timers by the AHB
// FIFO and smart_run logic. Each channel loads on the rising edge of its enable.
module ahb_multi_timer #(
  parameter int CNT_WIDTH = 32,
  parameter int CH_NUM    = 4
) (
  input  logic                        cpu_clk,
  input  logic                        cpu_rst_b,
  input  logic [CH_NUM-1:0]           counter_en,
  input  logic [CH_NUM*CNT_WIDTH-1:0] counter_load,
  input  logic [CH_NUM-1:0]           counter_mode,
  input  logic [CH_NUM-1:0]           counter_pause,
  output logic [CH_NUM-1:0]           counter_done,
  output logic [CH_NUM-1:0]           counter_expire,
  output logic [CH_NUM*CNT_WIDTH-1:0] counter_value,
  output logic                        expire_any
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] count, count_nxt;
    logic [CNT_WIDTH-1:0] reload, reload_nxt;
    logic [CNT_WIDTH-1:0] load_val;
    logic                 en_ff, mode_q, mode_nxt;
    logic                 expire_q, expire_nxt;
    logic                 load, abort;

    assign load_val = counter_load[ch*CNT_WIDTH +: CNT_WIDTH];
    assign load     = counter_en[ch] & ~en_ff;
    assign abort    = ~counter_en[ch] & en_ff;

    always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload;
      mode_nxt   = mode_q;
      expire_nxt = 1'b0;
      case (state)
        ST_IDLE: begin
          // Pause is deliberately not consulted here: a load always takes effect.
          if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            mode_nxt   = counter_mode[ch];
            if (load_val == '0) expire_nxt = 1'b1;
            else                state_nxt  = ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort outranks the terminal count so a dropped enable never pulses.
          if (abort) begin
            count_nxt = '0;
            state_nxt = ST_IDLE;
          end else if (counter_pause[ch]) begin
            count_nxt = count;
          end else if (count == CNT_ONE) begin
            expire_nxt = 1'b1;
            if (mode_q) begin
              count_nxt = reload;
            end else begin
              count_nxt = '0;
              state_nxt = ST_IDLE;
            end
          end else begin
            count_nxt = count - CNT_ONE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
      if (!cpu_rst_b) begin
        state    <= ST_IDLE;
        count    <= '0;
        reload   <= '0;
        mode_q   <= 1'b0;
        en_ff    <= 1'b0;
        expire_q <= 1'b0;
      end else begin
        state    <= state_nxt;
        count    <= count_nxt;
        reload   <= reload_nxt;
        mode_q   <= mode_nxt;
        en_ff    <= counter_en[ch];
        expire_q <= expire_nxt;
      end
    end

    assign counter_done[ch]                           = (state == ST_IDLE);
    assign counter_expire[ch]                         = expire_q;
    assign counter_value[ch*CNT_WIDTH +: CNT_WIDTH]   = count;
  end

  assign expire_any = |counter_expire;

endmodule

// File: tb/tb_ahb_multi_timer.sv
// Directed bench for ahb_multi_timer: one-shot, periodic, pause, abort, zero
// load, concurrent channels and reset mid-run, checked against hand values.
module tb_ahb_multi_timer;
  localparam int W = 32;
  localparam int N = 4;

  logic             cpu_clk = 1'b0;
  logic             cpu_rst_b;
  logic [N-1:0]     counter_en, counter_mode, counter_pause;
  logic [N-1:0]     counter_done, counter_expire;
  logic [N*W-1:0]   counter_load, counter_value;
  logic             expire_any;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 cpu_clk = ~cpu_clk;

  ahb_multi_timer #(.CNT_WIDTH(W), .CH_NUM(N)) u_dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst_b      (cpu_rst_b),
    .counter_en     (counter_en),
    .counter_load   (counter_load),
    .counter_mode   (counter_mode),
    .counter_pause  (counter_pause),
    .counter_done   (counter_done),
    .counter_expire (counter_expire),
    .counter_value  (counter_value),
    .expire_any     (expire_any)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(negedge cpu_clk);
  endtask

  task automatic set_load(input int ch, input logic [W-1:0] v);
    counter_load[ch*W +: W] = v;
  endtask

  function automatic logic [W-1:0] val(input int ch);
    return counter_value[ch*W +: W];
  endfunction

  // Expected value/expire k edges after the load edge, unpaused.
  function automatic int mval(input int l, input bit per, input int k);
    if (per) return (k % l == 0) ? l : l - (k % l);
    return (k < l) ? l - k : 0;
  endfunction

  function automatic bit mexp(input int l, input bit per, input int k);
    if (per) return (k > 0) && (k % l == 0);
    return k == l;
  endfunction

  initial begin
    int        ls [N];
    bit        ps [N];
    int        exp3 [8];
    logic [N-1:0] ev;

    cpu_rst_b     = 1'b0;
    counter_en    = '0;
    counter_mode  = '0;
    counter_pause = '0;
    counter_load  = '0;
    #1;
    check("reset done",   counter_done,   4'hF);
    check("reset expire", counter_expire, 4'h0);
    check("reset value",  counter_value,  '0);
    check("reset any",    expire_any,     1'b0);
    step();
    cpu_rst_b = 1'b1;
    step();

    // 1: ch0 one-shot load 5
    set_load(0, 5); counter_mode[0] = 1'b0; counter_en[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      check($sformatf("t1 value k=%0d", k),  val(0), (k <= 5) ? 5 - k : 0);
      check($sformatf("t1 expire k=%0d", k), counter_expire[0], k == 5);
      check($sformatf("t1 done k=%0d", k),   counter_done[0], k >= 5);
      check($sformatf("t1 any k=%0d", k),    expire_any, k == 5);
    end
    counter_en[0] = 1'b0;
    step();
    check("t1 idle fall value", val(0), 0);

    // 2: ch1 periodic load 3
    set_load(1, 3); counter_mode[1] = 1'b1; counter_en[1] = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step();
      check($sformatf("t2 value k=%0d", k),  val(1), (k % 3 == 0) ? 3 : 3 - (k % 3));
      check($sformatf("t2 expire k=%0d", k), counter_expire[1], (k > 0) && (k % 3 == 0));
      check($sformatf("t2 done k=%0d", k),   counter_done[1], 1'b0);
    end
    counter_en[1] = 1'b0;
    step();
    check("t2 abort value",  val(1), 0);
    check("t2 abort done",   counter_done[1], 1'b1);
    check("t2 abort expire", counter_expire[1], 1'b0);

    // 3: ch2 load 4, pause two cycles at value 2
    exp3 = '{4, 3, 2, 2, 2, 1, 0, 0};
    set_load(2, 4); counter_mode[2] = 1'b0; counter_en[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("t3 value k=%0d", k),  val(2), exp3[k]);
      check($sformatf("t3 expire k=%0d", k), counter_expire[2], k == 6);
      if (k == 2) counter_pause[2] = 1'b1;
      if (k == 4) counter_pause[2] = 1'b0;
    end
    counter_en[2] = 1'b0;
    step();

    // 4: ch3 load 10, enable dropped while value is 1
    set_load(3, 10); counter_mode[3] = 1'b0; counter_en[3] = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step();
      check($sformatf("t4 value k=%0d", k), val(3), 10 - k);
    end
    counter_en[3] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("t4 abort value %0d", k),  val(3), 0);
      check($sformatf("t4 abort done %0d", k),   counter_done[3], 1'b1);
      check($sformatf("t4 abort expire %0d", k), counter_expire[3], 1'b0);
      check($sformatf("t4 abort any %0d", k),    expire_any, 1'b0);
    end

    // 5a: zero load on ch1
    set_load(1, 0); counter_mode[1] = 1'b0; counter_en[1] = 1'b1;
    step();
    check("t5a value",  val(1), 0);
    check("t5a done",   counter_done[1], 1'b1);
    check("t5a expire", counter_expire, 4'b0010);
    check("t5a any",    expire_any, 1'b1);
    step();
    check("t5a expire2", counter_expire[1], 1'b0);
    check("t5a done2",   counter_done[1], 1'b1);
    counter_en[1] = 1'b0;
    step();

    // 5b: all channels concurrently
    ls = '{2, 3, 4, 5};
    ps = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < N; c++) begin
      set_load(c, ls[c]);
      counter_mode[c] = ps[c];
    end
    counter_en = '1;
    for (int k = 0; k <= 6; k++) begin
      step();
      ev = '0;
      for (int c = 0; c < N; c++) begin
        ev[c] = mexp(ls[c], ps[c], k);
        check($sformatf("t5b value ch%0d k=%0d", c, k), val(c), mval(ls[c], ps[c], k));
      end
      check($sformatf("t5b expire k=%0d", k), counter_expire, ev);
      check($sformatf("t5b any k=%0d", k),    expire_any, |ev);
    end
    counter_en = '0;
    step();

    // 5c: periodic load 1 pulses every cycle
    set_load(2, 1); counter_mode[2] = 1'b1; counter_en[2] = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      step();
      check($sformatf("t5c value k=%0d", k),  val(2), 1);
      check($sformatf("t5c expire k=%0d", k), counter_expire[2], k >= 1);
      check($sformatf("t5c done k=%0d", k),   counter_done[2], 1'b0);
    end
    counter_en[2] = 1'b0;
    step();
    check("t5c abort done", counter_done[2], 1'b1);

    // 6: reset mid-run with enable held high
    set_load(0, 7); counter_mode[0] = 1'b0; counter_en[0] = 1'b1;
    for (int k = 0; k <= 3; k++) step();
    check("t6 pre-reset value", val(0), 4);
    cpu_rst_b = 1'b0;
    #1;
    check("t6 rst value",  counter_value,  '0);
    check("t6 rst done",   counter_done,   4'hF);
    check("t6 rst expire", counter_expire, 4'h0);
    check("t6 rst any",    expire_any,     1'b0);
    set_load(0, 6);
    step();
    check("t6 held value", val(0), 0);
    cpu_rst_b = 1'b1;
    step();
    check("t6 reload value", val(0), 6);
    check("t6 reload done",  counter_done[0], 1'b0);
    step();
    check("t6 count value",  val(0), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
